nanov_periph_bus: RTL and testbench

Parametrised memory-mapped peripheral block for the nanoV SoC, sitting between the CPU's serial store/load strobes and the GPIO pins plus the existing `uart_tx`/`uart_rx` cores. It is the successor to the fixed single-register GPIO/UART decode. Additions over that decode:
- configurable GPIO width with a direction register;
- TX and RX FIFOs of parameterised depth, decoupling the CPU from UART byte timing;
- sticky error flags;
- a loadable free-running timer.

---
 rtl/nanov_periph_pkg.sv | 42 ++++
 rtl/nanov_sync_fifo.sv | 64 ++++++
 rtl/nanov_periph_bus.sv | 171 +++++++++++++++++
 tb/tb_nanov_periph_bus.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanov_periph_pkg.sv
// nanov_periph_pkg
// Register offsets, UART_STATUS bit positions, TX drain FSM states and the
// select-vector type shared by the nanoV peripheral block.
package nanov_periph_pkg;

  localparam logic [31:0] OFF_GPIO        = 32'h00;
  localparam logic [31:0] OFF_GPIO_OE     = 32'h04;
  localparam logic [31:0] OFF_UART_DATA   = 32'h10;
  localparam logic [31:0] OFF_UART_STATUS = 32'h14;
  localparam logic [31:0] OFF_TIMER       = 32'h18;

  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_RX_NONEMPTY  = 1;
  localparam int unsigned ST_RX_UNDERFLOW = 2;
  localparam int unsigned ST_TX_IDLE      = 3;
  localparam int unsigned ST_TX_DROP      = 4;
  localparam int unsigned ST_TX_BUSY      = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_ISSUE = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_e;

  // One-hot register select latched on addr_strobe.
  typedef struct packed {
    logic timer;
    logic status;
    logic data;
    logic oe;
    logic gpio;
  } sel_t;

  // Store data arrives bit-reversed on the CPU bus.
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31 - i];
    return r;
  endfunction

endpackage

// File: rtl/nanov_sync_fifo.sv
// nanov_sync_fifo
// Single-clock FIFO, DEPTH a power of two.
//   push/din  : write din when not full (full is the pre-pop value)
//   pop       : remove head when not empty
//   dout      : current head, combinational
//   full/empty: registered from the next count
//   count     : number of stored entries
module nanov_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import nanov_periph_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nanov_periph_bus.sv
// nanov_periph_bus
// Memory-mapped GPIO / UART FIFO / timer block for the nanoV SoC.
//   clk, rst_n                      : clock, synchronous active-low reset
//   addr_strobe/data_strobe/read_strobe, cpu_data : CPU serial bus strobes
//   rd_data                         : load data (combinational from select)
//   gpio_in/gpio_out/gpio_oe        : GPIO pins, output and direction regs
//   uart_tx_en/uart_tx_data/uart_tx_busy : handshake with uart_tx
//   uart_rx_valid/uart_rx_data/uart_rx_read : handshake with uart_rx
//   timer                           : free-running, loadable counter
module nanov_periph_bus #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned GPIO_W    = 8,
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned RX_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_strobe,
  input  logic              data_strobe,
  input  logic              read_strobe,
  input  logic [31:0]       cpu_data,
  output logic [31:0]       rd_data,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              uart_tx_en,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_tx_busy,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  output logic              uart_rx_read,
  output logic [31:0]       timer
);
  import nanov_periph_pkg::*;

  logic [31:0] wdata;
  logic [31:0] offset;
  sel_t        sel;
  sel_t        sel_nxt;
  logic [GPIO_W-1:0] gpio_in_q;
  logic        rx_underflow;
  logic        tx_drop;
  logic        ack_q;
  tx_state_e   tx_state;
  logic        wait_cnt;
  logic        wr_data, wr_status, rd_pop_req;

  logic [7:0]  tx_head, rx_head;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [$clog2(TX_DEPTH+1)-1:0] tx_count;
  logic [$clog2(RX_DEPTH+1)-1:0] rx_count;
  logic [31:0] status;

  assign wdata  = bit_rev32(cpu_data);
  assign offset = cpu_data - BASE_ADDR;

  always_comb begin
    sel_nxt        = '0;
    sel_nxt.gpio   = (offset == OFF_GPIO);
    sel_nxt.oe     = (offset == OFF_GPIO_OE);
    sel_nxt.data   = (offset == OFF_UART_DATA);
    sel_nxt.status = (offset == OFF_UART_STATUS);
    sel_nxt.timer  = (offset == OFF_TIMER);
  end

  assign wr_data    = data_strobe & sel.data;
  assign wr_status  = data_strobe & sel.status;
  assign rd_pop_req = read_strobe & sel.data;

  // ack_q blocks the cycle after an ack so uart_rx can drop valid first.
  assign uart_rx_read = rst_n & uart_rx_valid & ~rx_full & ~ack_q;

  nanov_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_data),
    .pop   (tx_state == TX_ISSUE),
    .din   (wdata[7:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  nanov_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (uart_rx_read),
    .pop   (rd_pop_req),
    .din   (uart_rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel          <= '0;
      gpio_out     <= '0;
      gpio_oe      <= '0;
      gpio_in_q    <= '0;
      timer        <= '0;
      rx_underflow <= 1'b0;
      tx_drop      <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      if (addr_strobe) sel <= sel_nxt;
      gpio_in_q <= gpio_in;
      ack_q     <= uart_rx_read;
      if (data_strobe && sel.gpio) gpio_out <= wdata[GPIO_W-1:0];
      if (data_strobe && sel.oe)   gpio_oe  <= wdata[GPIO_W-1:0];
      if (data_strobe && sel.timer) timer <= wdata;
      else                          timer <= timer + 32'd1;
      if (wr_data && tx_full)                        tx_drop <= 1'b1;
      else if (wr_status && wdata[ST_TX_DROP])       tx_drop <= 1'b0;
      if (rd_pop_req && rx_empty)                    rx_underflow <= 1'b1;
      else if (wr_status && wdata[ST_RX_UNDERFLOW])  rx_underflow <= 1'b0;
    end
  end

  // WAIT leaves on the first busy sighting or after its second cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state     <= TX_IDLE;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      wait_cnt     <= 1'b0;
    end else begin
      uart_tx_en <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty && !uart_tx_busy) begin
            tx_state     <= TX_ISSUE;
            uart_tx_en   <= 1'b1;
            uart_tx_data <= tx_head;
          end
        end
        TX_ISSUE: begin
          tx_state <= TX_WAIT;
          wait_cnt <= 1'b0;
        end
        TX_WAIT: begin
          if (uart_tx_busy || wait_cnt) tx_state <= TX_IDLE;
          else                          wait_cnt <= 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = tx_full;
    status[ST_RX_NONEMPTY]  = (rx_count != '0);
    status[ST_RX_UNDERFLOW] = rx_underflow;
    status[ST_TX_IDLE]      = (tx_count == '0) && (tx_state == TX_IDLE) && !uart_tx_busy;
    status[ST_TX_DROP]      = tx_drop;
    status[ST_TX_BUSY]      = uart_tx_busy;
  end

  always_comb begin
    rd_data = '0;
    if (sel.gpio)   rd_data = 32'(gpio_in_q);
    if (sel.oe)     rd_data = 32'(gpio_oe);
    if (sel.data)   rd_data = rx_empty ? 32'd0 : 32'(rx_head);
    if (sel.status) rd_data = status;
    if (sel.timer)  rd_data = timer;
  end

endmodule

// File: tb/tb_nanov_periph_bus.sv
module tb_nanov_periph_bus;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_GPIO = 32'h00, A_OE = 32'h04, A_DATA = 32'h10,
                          A_STAT = 32'h14, A_TIMER = 32'h18;

  logic        clk, rst_n;
  logic        addr_strobe, data_strobe, read_strobe;
  logic [31:0] cpu_data, rd_data, timer;
  logic [7:0]  gpio_in, gpio_out, gpio_oe;
  logic        uart_tx_en, uart_tx_busy, uart_rx_valid, uart_rx_read;
  logic [7:0]  uart_tx_data, uart_rx_data;

  nanov_periph_bus #(.BASE_ADDR(BASE), .GPIO_W(8), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr_strobe(addr_strobe), .data_strobe(data_strobe),
    .read_strobe(read_strobe), .cpu_data(cpu_data), .rd_data(rd_data),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_read(uart_rx_read),
    .timer(timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] rx_src[$];
  bit m_drop = 0, m_under = 0;
  logic [7:0] m_gpio = '0, m_oe = '0;

  // uart core models
  bit force_busy = 0, rx_force = 0;
  int bcnt = 0, en_cnt = 0, ack_cnt = 0;
  bit prev_en = 0, ack_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rev(input logic [31:0] v);
    return {<<{v}};
  endfunction

  // uart_tx stand-in: goes busy for a random time after every start pulse.
  always @(negedge clk) begin
    bit was_busy;
    was_busy = uart_tx_busy;
    if (!rst_n) begin
      bcnt = 0;
      prev_en = 0;
    end else begin
      if (uart_tx_en) begin
        en_cnt++;
        check("tx_en_single_cycle", 32'(prev_en), 32'd0);
        check("tx_en_while_busy", 32'(was_busy), 32'd0);
        if (txq.size() == 0) check("tx_unexpected_en", 32'(uart_tx_en), 32'd0);
        else check("tx_byte_order", 32'(uart_tx_data), 32'(txq.pop_front()));
        bcnt = $urandom_range(3, 8);
      end else if (bcnt > 0) bcnt--;
      prev_en = uart_tx_en;
    end
    uart_tx_busy = force_busy || (bcnt > 0);
  end

  // uart_rx stand-in: presents the next byte; an ack consumes it.
  always @(negedge clk) begin
    if (ack_seen && rx_src.size() > 0) void'(rx_src.pop_front());
    uart_rx_valid = rx_force || (rx_src.size() > 0);
    uart_rx_data  = (rx_src.size() > 0) ? rx_src[0] : 8'h00;
    #2;
    ack_seen = uart_rx_read;
    if (ack_seen && rx_src.size() > 0) begin
      rxq.push_back(rx_src[0]);
      ack_cnt++;
    end
  end

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
    @(negedge clk); addr_strobe = 1; cpu_data = BASE + off;
    @(negedge clk); addr_strobe = 0; data_strobe = 1; cpu_data = rev(data);
    case (off)
      A_GPIO: m_gpio = data[7:0];
      A_OE:   m_oe = data[7:0];
      A_DATA: if (txq.size() < 4) txq.push_back(data[7:0]); else m_drop = 1;
      A_STAT: begin
        if (data[2]) m_under = 0;
        if (data[4]) m_drop = 0;
      end
      default: ;
    endcase
    @(negedge clk); data_strobe = 0; cpu_data = '0;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] v);
    @(negedge clk); addr_strobe = 1; cpu_data = BASE + off;
    @(negedge clk); addr_strobe = 0; cpu_data = '0;
    #1 v = rd_data; read_strobe = 1;
    @(negedge clk); read_strobe = 0;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] v, e;
    bus_read(A_DATA, v);
    if (rxq.size() == 0) begin e = 0; m_under = 1; end
    else e = 32'(rxq.pop_front());
    check(tag, v, e);
  endtask

  // Only called when the TX side has settled.
  task automatic read_status(input string tag);
    logic [31:0] e;
    @(negedge clk); addr_strobe = 1; cpu_data = BASE + A_STAT;
    @(negedge clk); addr_strobe = 0; cpu_data = '0;
    #1;
    e = '0;
    e[0] = (txq.size() == 4);
    e[1] = (rxq.size() != 0);
    e[2] = m_under;
    e[3] = (txq.size() == 0) && !uart_tx_busy;
    e[4] = m_drop;
    e[5] = uart_tx_busy;
    check(tag, rd_data, e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (txq.size() != 0 || uart_tx_busy); i++) @(negedge clk);
    check("tx_drain_timeout", 32'(txq.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] v, r;
    int e0, k, n;
    rst_n = 0; addr_strobe = 0; data_strobe = 0; read_strobe = 0;
    cpu_data = '0; gpio_in = '0;

    // Reset state, with uart_rx_valid forced to prove the ack is held low.
    rx_force = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_data", rd_data, 0);
    check("rst_gpio_out", 32'(gpio_out), 0);
    check("rst_gpio_oe", 32'(gpio_oe), 0);
    check("rst_timer", timer, 0);
    check("rst_tx_en", 32'(uart_tx_en), 0);
    check("rst_tx_data", 32'(uart_tx_data), 0);
    check("rst_rx_read", 32'(uart_rx_read), 0);
    rx_force = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // GPIO
    bus_write(A_GPIO, 32'h5A);
    #1 check("gpio_out_5a", 32'(gpio_out), 32'h5A);
    gpio_in = 8'hC3;
    bus_read(A_GPIO, r);
    check("gpio_in_c3", r, 32'hC3);
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      bus_write(A_GPIO, v);
      #1 check("gpio_out_rand", 32'(gpio_out), 32'(m_gpio));
      bus_write(A_OE, $urandom);
      #1 check("gpio_oe_rand", 32'(gpio_oe), 32'(m_oe));
      bus_read(A_OE, r);
      check("gpio_oe_read", r, 32'(m_oe));
      gpio_in = 8'($urandom);
      bus_read(A_GPIO, r);
      check("gpio_in_rand", r, 32'(gpio_in));
    end
    // One-flop pin latency with the GPIO select held
    v = 32'(gpio_in);
    @(negedge clk); gpio_in = ~gpio_in;
    #1 check("gpio_lat_old", rd_data, v);
    @(negedge clk); #1 check("gpio_lat_new", rd_data, 32'(gpio_in));

    // TX overflow while busy, then ordered drain
    force_busy = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'h41 + i);
    read_status("stat_tx_full_drop");
    e0 = en_cnt;
    force_busy = 0;
    wait_drain();
    check("tx_pulse_count", en_cnt - e0, 4);
    read_status("stat_after_drain");
    bus_write(A_STAT, 32'h10);
    read_status("stat_drop_cleared");

    // Random TX bursts
    for (int j = 0; j < 3; j++) begin
      force_busy = 1;
      @(negedge clk);
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) bus_write(A_DATA, $urandom);
      e0 = en_cnt;
      force_busy = 0;
      wait_drain();
      check("tx_rand_count", en_cnt - e0, k);
    end

    // RX fill with backpressure
    e0 = ack_cnt;
    for (int i = 0; i < 5; i++) rx_src.push_back(8'h10 + 8'(i));
    repeat (30) @(negedge clk);
    #3;
    check("rx_ack_count", ack_cnt - e0, 4);
    check("rx_valid_held", 32'(uart_rx_valid), 1);
    check("rx_no_ack_full", 32'(uart_rx_read), 0);
    read_status("stat_rx_full");
    for (int i = 0; i < 5; i++) read_data("rx_read_seq");
    check("rx_all_acked", ack_cnt - e0, 5);

    for (int j = 0; j < 3; j++) rx_src.push_back(8'($urandom));
    repeat (15) @(negedge clk);
    for (int j = 0; j < 3; j++) read_data("rx_read_rand");

    // RX underflow and clear
    read_data("rx_empty_read");
    read_status("stat_underflow");
    bus_write(A_STAT, 32'h04);
    read_status("stat_underflow_clr");

    // Timer load and wrap
    bus_write(A_TIMER, 32'hFFFF_FFFE);
    #1 check("timer_load", rd_data, 32'hFFFF_FFFE);
    @(negedge clk); #1 check("timer_ffff", rd_data, 32'hFFFF_FFFF);
    @(negedge clk); #1 check("timer_wrap", rd_data, 32'h0);
    v = $urandom;
    bus_write(A_TIMER, v);
    n = $urandom_range(1, 20);
    repeat (n) @(negedge clk);
    #1 check("timer_rand", timer, v + 32'(n));

    // Reset mid-drain
    force_busy = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'hA1 + i);
    bus_write(A_GPIO, 32'hFF);
    e0 = en_cnt;
    force_busy = 0;
    for (int i = 0; i < 50 && en_cnt == e0; i++) @(negedge clk);
    check("drain_started", en_cnt - e0, 1);
    rst_n = 0;
    txq.delete(); rxq.delete();
    m_drop = 0; m_under = 0; m_gpio = '0; m_oe = '0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_rst_gpio_out", 32'(gpio_out), 0);
    check("mid_rst_tx_en", 32'(uart_tx_en), 0);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_timer", timer, 0);
    e0 = en_cnt;
    rst_n = 1;
    for (int i = 0; i < 50 && uart_tx_busy; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("no_tx_after_rst", en_cnt - e0, 0);
    read_status("stat_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
